arr_stream_reg: RTL
===================

# arr_stream_reg

Parametrised N_ELEM × ELEM_W array register that accepts whole-vector loads and single-element writes, and exposes the full vector plus an indexed element read. It adds a valid/ready element-streaming engine with an optional zero-skip mode. That mode emits only the nonzero entries of a loaded row, with their indices, to the downstream SpMM multiply-accumulate lane. It sits between the row fetch path and the MAC lane.

## Interface
- ELEM_W, 32, element width in bits
- N_ELEM, 16, element count (≥2; non-power-of-2 allowed)
- IDX_W, $clog2(N_ELEM), index width (derived)
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- vec_valid_i  in  1  whole-vector load request
- vec_ready_o  out  1  load accepted when high (IDLE only)
- vec_d_i  in  N_ELEM*ELEM_W  vector; element k at [(N_ELEM-k)*ELEM_W-1 -: ELEM_W] (element 0 in MSBs)
- elem_wr_en_i  in  1  single-element write
- elem_wr_idx_i  in  IDX_W  write index
- elem_wr_d_i  in  ELEM_W  write data
- rd_idx_i  in  IDX_W  random-read index
- rd_elem_o  out  ELEM_W  element at rd_idx_i, combinational from storage
- q_o  out  N_ELEM*ELEM_W  full storage, same element mapping
- stream_start_i  in  1  start streaming (sampled in IDLE)
- skip_zero_i  in  1  zero-skip mode, captured with stream_start_i
- stream_valid_o / stream_ready_i  out/in  1  element handshake
- stream_elem_o  out  ELEM_W  streamed element
- stream_idx_o  out  IDX_W  its index
- stream_last_o  out  1  final beat of this stream
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse, stream complete

## Operation
- States: IDLE, STREAM.
- IDLE:
  - vec_ready_o=1. The vector handshake writes all elements at the next edge.
  - elem_wr_en_i writes one element. If it coincides with a vector load, the element write wins for that index.
  - An elem_wr_idx_i ≥ N_ELEM is ignored.
- STREAM:
  - vec_ready_o=0. elem_wr_en_i is ignored, so storage is frozen.
- stream_start_i in IDLE:
  - Latches skip_zero_i into mode_q and sets ptr to the first eligible index: 0 in dense mode, the lowest nonzero index in skip mode.
  - Moves to STREAM.
  - A load or write in the same cycle takes effect, and the stream uses the updated contents.
  - stream_start_i outside IDLE is ignored.
- Skip mode with no nonzero element: stay in IDLE, emit no beats, pulse done_o the next cycle.
- In STREAM:
  - stream_valid_o=1, stream_elem_o=elem[ptr], stream_idx_o=ptr.
  - stream_last_o=1 when no eligible index exists above ptr: ptr==N_ELEM-1 in dense mode, no nonzero above ptr in skip mode.
- On handshake:
  - ptr advances to the next eligible index.
  - If last, go to IDLE, clear ptr, pulse done_o the next cycle.
- While stream_ready_i=0, all stream outputs hold stable.
- rd_idx_i ≥ N_ELEM gives rd_elem_o=0.
- Elements are opaque bit patterns. "Zero" means all ELEM_W bits are 0, so -0.0 is nonzero.

## Timing
- Reset values:
  - storage 0, q_o 0, state IDLE, ptr 0
  - vec_ready_o 1
  - stream_valid_o 0, stream_last_o 0, busy_o 0, done_o 0
  - stream_elem_o 0, stream_idx_o 0
  - rd_elem_o follows storage, so 0
- Reset is asynchronous at any time, including mid-stream: the stream is aborted and no done_o pulse is produced.
- Load/write to q_o latency: 1 cycle.
- Start to first stream_valid_o: 1 cycle.
- With stream_ready_i held at 1, throughput is 1 element/cycle, including across skipped zeros (no bubbles).
- Last handshake at edge t: busy_o=0 and done_o=1 during cycle t+1.
- A new start is accepted during that cycle.
- stream_valid_o, stream_last_o, stream_elem_o and stream_idx_o are functions of registered state only, with no combinational path from stream_ready_i.

## Structure
- Package arr_pkg holds:
  - state enum arr_state_e {IDLE, STREAM}
  - default ELEM_W/N_ELEM localparams
  - element-slice helper function implementing the MSB-first mapping
- Sub-module arr_next_nz:
  - inputs: N_ELEM-bit nonzero mask, ptr, inclusive/exclusive select
  - outputs: next set index, found flag
  - purely combinational; serves both the first-index search at start and the advance/last computation

## Test plan
- Reset, then load vector elements 0..15 = 1..16 → next cycle q_o[511:480]=1, q_o[31:0]=16; rd_idx_i=5 gives 6.
- Same cycle: vector load of all 0xAAAAAAAA plus elem write idx 3 = 0x1234 → elem[3]=0x1234, all others 0xAAAAAAAA.
- Dense stream with ready=1 → 16 consecutive beats idx 0..15, last on idx 15, done_o one cycle after.
- Ready toggled 1,0,0,1 during the stream → outputs frozen while low, no beat lost or duplicated.
- Skip mode with nonzeros only at idx 2, 7, 15 → 3 back-to-back beats (2,7,15), last on 15. All-zero vector → no beats, done_o pulse.
- Elem write and vector load during STREAM → ignored (vec_ready_o=0). rst_i mid-stream → all outputs at reset values immediately, q_o=0.

Source files
------------

// File: rtl/arr_stream_reg_pkg.sv
// Shared types and helpers for the array stream register.
package arr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arr_state_e;

  localparam int unsigned ELEM_W_DEF = 32;
  localparam int unsigned N_ELEM_DEF = 16;

  // LSB position of element k in a packed vector, element 0 in the MSBs.
  function automatic int unsigned elem_lsb(input int unsigned n_elem,
                                           input int unsigned elem_w,
                                           input int unsigned k);
    return (n_elem - 1 - k) * elem_w;
  endfunction

endpackage

// File: rtl/arr_stream_reg_next_nz.sv
// Finds the lowest set mask bit at or above (inclusive) / above (exclusive)
// a pointer. Purely combinational.
module arr_next_nz #(
  parameter  int unsigned N_ELEM = 16,
  localparam int unsigned IDX_W  = $clog2(N_ELEM)
) (
  input  logic [N_ELEM-1:0] i_mask,
  input  logic [IDX_W-1:0]  i_ptr,
  input  logic              i_incl,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_found
);

  // Scan from the top down so the lowest qualifying index is the last one kept.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned k = N_ELEM; k > 0; k--) begin
      if (i_mask[k-1] &&
          (((k - 1) > 32'(i_ptr)) || (i_incl && ((k - 1) == 32'(i_ptr))))) begin
        o_idx   = IDX_W'(k - 1);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arr_stream_reg.sv
// N_ELEM x ELEM_W array register with vector/element writes, indexed read,
// and a valid/ready element streamer with optional zero-skip.
module arr_stream_reg import arr_pkg::*; #(
  parameter  int unsigned ELEM_W = ELEM_W_DEF,
  parameter  int unsigned N_ELEM = N_ELEM_DEF,
  localparam int unsigned IDX_W  = $clog2(N_ELEM)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     vec_valid_i,
  output logic                     vec_ready_o,
  input  logic [N_ELEM*ELEM_W-1:0] vec_d_i,
  input  logic                     elem_wr_en_i,
  input  logic [IDX_W-1:0]         elem_wr_idx_i,
  input  logic [ELEM_W-1:0]        elem_wr_d_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [ELEM_W-1:0]        rd_elem_o,
  output logic [N_ELEM*ELEM_W-1:0] q_o,
  input  logic                     stream_start_i,
  input  logic                     skip_zero_i,
  output logic                     stream_valid_o,
  input  logic                     stream_ready_i,
  output logic [ELEM_W-1:0]        stream_elem_o,
  output logic [IDX_W-1:0]         stream_idx_o,
  output logic                     stream_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  logic [ELEM_W-1:0] r_mem     [N_ELEM];
  logic [ELEM_W-1:0] w_mem_nxt [N_ELEM];
  arr_state_e        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_mode;
  logic              r_done;
  logic [N_ELEM-1:0] w_nz_nxt;
  logic [N_ELEM-1:0] w_nz_cur;
  logic [IDX_W-1:0]  w_first_idx;
  logic              w_first_found;
  logic [IDX_W-1:0]  w_adv_idx;
  logic              w_adv_found;
  logic              w_idle;
  logic              w_wr_ok;
  logic              w_last;

  assign w_idle  = (r_state == IDLE);
  assign w_wr_ok = elem_wr_en_i && (32'(elem_wr_idx_i) < N_ELEM);

  // Next storage contents: vector load, then element write overriding its slot.
  always_comb begin
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      w_mem_nxt[k] = r_mem[k];
      if (w_idle) begin
        if (vec_valid_i) begin
          w_mem_nxt[k] = vec_d_i[elem_lsb(N_ELEM, ELEM_W, k) +: ELEM_W];
        end
        if (w_wr_ok && (elem_wr_idx_i == IDX_W'(k))) begin
          w_mem_nxt[k] = elem_wr_d_i;
        end
      end
    end
  end

  // Nonzero masks: next contents feed the start search, current feed the advance.
  always_comb begin
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      w_nz_nxt[k] = |w_mem_nxt[k];
      w_nz_cur[k] = |r_mem[k];
    end
  end

  arr_next_nz #(.N_ELEM(N_ELEM)) u_first (
    .i_mask  (w_nz_nxt),
    .i_ptr   ('0),
    .i_incl  (1'b1),
    .o_idx   (w_first_idx),
    .o_found (w_first_found)
  );

  arr_next_nz #(.N_ELEM(N_ELEM)) u_adv (
    .i_mask  (w_nz_cur),
    .i_ptr   (r_ptr),
    .i_incl  (1'b0),
    .o_idx   (w_adv_idx),
    .o_found (w_adv_found)
  );

  // Last beat: no eligible index above the pointer in the latched mode.
  always_comb begin
    w_last = 1'b0;
    if (!w_idle) begin
      w_last = r_mode ? !w_adv_found : (r_ptr == IDX_W'(N_ELEM - 1));
    end
  end

  // Storage register; writes only take effect in IDLE via w_mem_nxt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < N_ELEM; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      r_mem <= w_mem_nxt;
    end
  end

  // Stream control FSM with registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (stream_start_i) begin
            r_mode <= skip_zero_i;
            if (skip_zero_i && !w_first_found) begin
              r_done <= 1'b1;
            end else begin
              r_state <= STREAM;
              r_ptr   <= skip_zero_i ? w_first_idx : '0;
            end
          end
        end
        STREAM: begin
          if (stream_ready_i) begin
            if (w_last) begin
              r_state <= IDLE;
              r_ptr   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_ptr <= r_mode ? w_adv_idx : (r_ptr + IDX_W'(1));
            end
          end
        end
      endcase
    end
  end

  // Element selection for the stream and random-read ports, plus packed view.
  always_comb begin
    stream_elem_o = '0;
    rd_elem_o     = '0;
    q_o           = '0;
    for (int unsigned k = 0; k < N_ELEM; k++) begin
      if (!w_idle && (r_ptr == IDX_W'(k))) begin
        stream_elem_o = r_mem[k];
      end
      if (rd_idx_i == IDX_W'(k)) begin
        rd_elem_o = r_mem[k];
      end
      q_o[elem_lsb(N_ELEM, ELEM_W, k) +: ELEM_W] = r_mem[k];
    end
  end

  assign vec_ready_o    = w_idle;
  assign busy_o         = !w_idle;
  assign done_o         = r_done;
  assign stream_valid_o = !w_idle;
  assign stream_last_o  = w_last;
  assign stream_idx_o   = r_ptr;

endmodule
